// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants shared by the clk_50 monitor pipeline.
package vga_timing_pkg;

   localparam int COORD_W = 10;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/pixel_tick_gen.sv
// Divide-by-2 clock enable: pix_en is high on every second clk_50 cycle, low in reset.
module pixel_tick_gen (
   input  logic clk_50,
   input  logic rst,
   output logic pix_en
);

   always_ff @(posedge clk_50) begin
      if (rst) pix_en <= 1'b0;
      else     pix_en <= ~pix_en;
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/coordinate generator running in the clk_50 domain on a 25 MHz pixel enable.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic               clk_50,
   input  logic               rst,
   output logic               pix_en,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS     = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_VIS     = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_FIRST  = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_FIRST  = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [COORD_W-1:0] x_nxt;
   logic [COORD_W-1:0] y_nxt;
   logic               started;
   logic               fs_nxt;

   pixel_tick_gen u_tick (
      .clk_50 (clk_50),
      .rst    (rst),
      .pix_en (pix_en)
   );

   // Next-state counters; line and frame wrap resolve on the same edge.
   always_comb begin
      x_nxt = pixel_x;
      y_nxt = pixel_y;
      if (pix_en) begin
         if (pixel_x == H_LAST) begin
            x_nxt = '0;
            y_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
         end else begin
            x_nxt = pixel_x + 1'b1;
         end
      end
   end

   // (0,0) is entered either by a frame wrap or by the first edge after reset.
   assign fs_nxt = (x_nxt == '0) && (y_nxt == '0) && (pix_en || !started);

   // Registered stage: flags derived from next-state counters stay aligned with them.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         pixel_x     <= '0;
         pixel_y     <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
         started     <= 1'b0;
      end else begin
         pixel_x     <= x_nxt;
         pixel_y     <= y_nxt;
         hsync       <= (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
         vsync       <= (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
         video_on    <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
         frame_start <= fs_nxt;
         started     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size and shrunk-timing instances checked against a closed-form model.
module tb_vga_sync_gen;

   typedef struct packed {
      logic       pe;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       von;
      logic       fs;
   } obs_t;

   typedef struct packed {
      obs_t s;
      obs_t p;
      obs_t d;
   } trio_t;

   typedef struct {
      logic r;
      obs_t e;
   } vec_t;

   logic clk_50 = 1'b0;
   logic rst    = 1'b1;
   always #10 clk_50 = ~clk_50;

   logic       pe_s, hs_s, vs_s, von_s, fs_s;
   logic       pe_p, hs_p, vs_p, von_p, fs_p;
   logic       pe_d, hs_d, vs_d, von_d, fs_d;
   logic [9:0] x_s, y_s, x_p, y_p, x_d, y_d;
   obs_t       o_s, o_p, o_d;

   assign o_s = {pe_s, x_s, y_s, hs_s, vs_s, von_s, fs_s};
   assign o_p = {pe_p, x_p, y_p, hs_p, vs_p, von_p, fs_p};
   assign o_d = {pe_d, x_d, y_d, hs_d, vs_d, von_d, fs_d};

   // Shrunk timing: H_TOTAL 16, V_TOTAL 8, hsync x 10..12, vsync y 5..6, frame 256 cycles.
   vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)) dut_s (
      .clk_50(clk_50), .rst(rst), .pix_en(pe_s), .pixel_x(x_s), .pixel_y(y_s),
      .hsync(hs_s), .vsync(vs_s), .video_on(von_s), .frame_start(fs_s));

   vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)) dut_p (
      .clk_50(clk_50), .rst(rst), .pix_en(pe_p), .pixel_x(x_p), .pixel_y(y_p),
      .hsync(hs_p), .vsync(vs_p), .video_on(von_p), .frame_start(fs_p));

   vga_sync_gen dut_d (
      .clk_50(clk_50), .rst(rst), .pix_en(pe_d), .pixel_x(x_d), .pixel_y(y_d),
      .hsync(hs_d), .vsync(vs_d), .video_on(von_d), .frame_start(fs_d));

   int    errors = 0;
   int    checks = 0;
   int    n      = 0;
   int    gc     = 0;
   int    hs_cnt = 0;
   int    fs_t[$];
   trio_t sb[$];
   vec_t  tbl[8];

   // k = edges since reset release; value index advances on odd edges.
   function automatic obs_t model(int k, int ha, int hfp, int hsw, int hbp,
                                  int va, int vfp, int vsw, int vbp, logic pol);
      obs_t o;
      int ht, vt, idx, x, y;
      ht    = ha + hfp + hsw + hbp;
      vt    = va + vfp + vsw + vbp;
      idx   = (k + 1) / 2;
      x     = idx % ht;
      y     = (idx / ht) % vt;
      o.pe  = (k % 2 == 0);
      o.x   = 10'(x);
      o.y   = 10'(y);
      o.hs  = (x >= ha + hfp && x < ha + hfp + hsw) ? pol : ~pol;
      o.vs  = (y >= va + vfp && y < va + vfp + vsw) ? pol : ~pol;
      o.von = (x < ha) && (y < va);
      o.fs  = (k == 0) || ((k + 1) % (2 * ht * vt) == 0);
      return o;
   endfunction

   function automatic obs_t rst_obs(logic pol);
      obs_t o;
      o     = '0;
      o.hs  = ~pol;
      o.vs  = ~pol;
      return o;
   endfunction

   task automatic check_obs(input string nm, input obs_t a, input obs_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s cyc=%0d: got pe=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b, expected pe=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
                  nm, gc, a.pe, a.x, a.y, a.hs, a.vs, a.von, a.fs,
                  e.pe, e.x, e.y, e.hs, e.vs, e.von, e.fs);
      end
   endtask

   task automatic check_int(input string nm, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, a, e);
      end
   endtask

   // One clk_50 cycle: push model expectation, clock, pop and compare all instances.
   task automatic cyc(input logic r);
      trio_t e;
      trio_t got;
      rst = r;
      if (r) begin
         e.s = rst_obs(1'b0);
         e.p = rst_obs(1'b1);
         e.d = rst_obs(1'b0);
      end else begin
         e.s = model(n, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0);
         e.p = model(n, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1);
         e.d = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      end
      sb.push_back(e);
      @(posedge clk_50);
      #1;
      gc++;
      if (r) n = 0;
      else   n++;
      got = sb.pop_front();
      check_obs("small_pol0", o_s, got.s);
      check_obs("small_pol1", o_p, got.p);
      check_obs("full_640", o_d, got.d);
      if (fs_s === 1'b1) fs_t.push_back(gc);
      if (!r && y_d == 10'd0 && hs_d == 1'b0) hs_cnt++;
   endtask

   initial begin
      int guard;

      tbl[0] = '{1'b1, {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[1] = '{1'b1, {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[2] = '{1'b1, {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[3] = '{1'b0, {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}};
      tbl[4] = '{1'b0, {1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
      tbl[5] = '{1'b0, {1'b1, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
      tbl[6] = '{1'b0, {1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
      tbl[7] = '{1'b0, {1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};

      // Power-up: reset held, then release.
      for (int i = 0; i < 8; i++) begin
         cyc(tbl[i].r);
         check_obs("powerup_tbl", o_s, tbl[i].e);
      end

      // Free run: several small frames and more than one full 640x480 line.
      for (int i = 0; i < 2000; i++) cyc(1'b0);
      check_int("hsync_cycles_line0", hs_cnt, 192);
      check_int("frame_start_count", fs_t.size(), 8);
      if (fs_t.size() >= 3) check_int("frame_start_period", fs_t[2] - fs_t[1], 256);

      // Mid-frame reset for one cycle, then replay the power-up sequence.
      guard = 0;
      while (!(x_s == 10'd5 && y_s == 10'd3) && guard < 600) begin
         cyc(1'b0);
         guard++;
      end
      check_int("reach_5_3", (guard < 600) ? 1 : 0, 1);
      cyc(1'b1);
      check_obs("midframe_rst", o_s, tbl[2].e);
      for (int i = 3; i < 8; i++) begin
         cyc(1'b0);
         check_obs("restart_tbl", o_s, tbl[i].e);
      end

      // Run across another frame wrap after the restart.
      for (int i = 0; i < 300; i++) cyc(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
